// File: rtl/key_pulse_gen.sv
// key_pulse_gen: multi-channel key synchroniser, debouncer and press/repeat pulse generator
module key_pulse_gen #(
    parameter int CHANNELS        = 4,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_EN       = 0,
    parameter int REPEAT_DELAY    = 16,
    parameter int REPEAT_RATE     = 8
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [CHANNELS-1:0] keys_in,
    input  logic                enable,
    output logic [CHANNELS-1:0] key_level,
    output logic [CHANNELS-1:0] key_pulse,
    output logic                any_pulse
);
    localparam int CW   = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RW   = $clog2(RMAX + 1);

    logic [CHANNELS-1:0] w_pulse_nx;
    logic                r_any;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic          r_s1, r_s2, r_st, r_armed, r_pulse;
        logic [CW-1:0] r_cnt;
        logic          w_hit, w_st_nx, w_armed_nx, w_lvl, w_lvl_nx, w_fire;

        assign w_hit         = (r_s2 != r_st) && (r_cnt == CW'(DEBOUNCE_CYCLES - 1));
        assign w_st_nx       = w_hit ? r_s2 : r_st;
        assign w_armed_nx    = r_armed | (w_hit & ~r_s2);
        assign w_lvl         = r_st & r_armed;
        assign w_lvl_nx      = w_st_nx & w_armed_nx;
        assign w_pulse_nx[i] = enable & w_lvl_nx & (~w_lvl | w_fire);
        assign key_level[i]  = w_lvl;
        assign key_pulse[i]  = r_pulse;

        // sync chain, debounce counter, debounced state, arming and pulse register
        always_ff @(posedge clock) begin
            if (reset) begin
                r_s1    <= 1'b0;
                r_s2    <= 1'b0;
                r_cnt   <= '0;
                r_st    <= 1'b1;
                r_armed <= 1'b0;
                r_pulse <= 1'b0;
            end else begin
                r_s1    <= keys_in[i];
                r_s2    <= r_s1;
                r_cnt   <= (r_s2 == r_st || w_hit) ? '0 : r_cnt + CW'(1);
                r_st    <= w_st_nx;
                r_armed <= w_armed_nx;
                r_pulse <= w_pulse_nx[i];
            end
        end

        if (REPEAT_EN != 0) begin : g_rep
            logic [RW-1:0] r_rcnt;
            logic          r_rep, w_run, w_press, w_tgt;

            assign w_run   = w_lvl_nx & enable;
            assign w_press = w_lvl_nx & ~w_lvl;
            assign w_tgt   = r_rcnt == (r_rep ? RW'(REPEAT_RATE) : RW'(REPEAT_DELAY));
            assign w_fire  = w_run & ~w_press & w_tgt;

            // cycles since the last pulse (or since enable returned); r_rep selects delay vs rate
            always_ff @(posedge clock) begin
                if (reset || !w_run) begin
                    r_rcnt <= '0;
                    r_rep  <= 1'b0;
                end else if (w_press) begin
                    r_rcnt <= RW'(1);
                    r_rep  <= 1'b0;
                end else if (w_tgt) begin
                    r_rcnt <= RW'(1);
                    r_rep  <= 1'b1;
                end else begin
                    r_rcnt <= r_rcnt + RW'(1);
                end
            end
        end else begin : g_norep
            assign w_fire = 1'b0;
        end
    end

    // any_pulse registered in the same cycle as the per-channel pulses
    always_ff @(posedge clock) begin
        if (reset) r_any <= 1'b0;
        else       r_any <= |w_pulse_nx;
    end

    assign any_pulse = r_any;
endmodule
